// File: rtl/rw_request_scheduler_pkg.sv
// Shared command type, scheduler state encoding and default scheduling constants
// for the read/write request scheduler.
package rw_request_scheduler_pkg;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  tag;
    } frontend_command_t;

    typedef enum logic {
        READ_PRIO   = 1'b0,
        WRITE_DRAIN = 1'b1
    } scheduler_state_t;

    localparam int SCHED_STARVE_LIMIT = 8;
    localparam int SCHED_DRAIN_BURST  = 4;

endpackage

// File: rtl/cmd_issue_slot.sv
// One-entry valid/ready issue register; o_load says the slot may take a new command
// this cycle (empty, or its current command is being accepted).
module cmd_issue_slot
    import rw_request_scheduler_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  frontend_command_t i_push_cmd,
    input  logic              i_push_is_write,
    input  logic              i_ready,
    output logic              o_load,
    output logic              o_valid,
    output frontend_command_t o_cmd,
    output logic              o_is_write
);

    logic              valid_q, valid_d;
    frontend_command_t cmd_q, cmd_d;
    logic              is_write_q, is_write_d;

    assign o_load = !valid_q || i_ready;

    always_comb begin
        valid_d    = valid_q;
        cmd_d      = cmd_q;
        is_write_d = is_write_q;
        if (o_load) begin
            // An accepted command with nothing behind it leaves the slot empty.
            valid_d = i_push;
            if (i_push) begin
                cmd_d      = i_push_cmd;
                is_write_d = i_push_is_write;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q    <= 1'b0;
            cmd_q      <= '0;
            is_write_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            cmd_q      <= cmd_d;
            is_write_q <= is_write_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_cmd      = cmd_q;
    assign o_is_write = is_write_q;

endmodule

// File: rtl/rw_request_scheduler.sv
// Arbitrates read/write FIFO heads onto one backend command port: reads first,
// writes forced after STARVE_LIMIT read grants, bursts of writes when the write FIFO fills.
module rw_request_scheduler
    import rw_request_scheduler_pkg::*;
#(
    parameter int STARVE_LIMIT = SCHED_STARVE_LIMIT,
    parameter int DRAIN_BURST  = SCHED_DRAIN_BURST
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  frontend_command_t i_rd_cmd,
    input  logic              i_rd_empty,
    output logic              o_rd_pop,
    input  frontend_command_t i_wr_cmd,
    input  logic              i_wr_empty,
    input  logic              i_wr_full,
    output logic              o_wr_pop,
    output logic              o_cmd_valid,
    output frontend_command_t o_cmd,
    output logic              o_cmd_is_write,
    input  logic              i_cmd_ready,
    output logic              o_drain_active
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(DRAIN_BURST + 1);

    scheduler_state_t state_q, state_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic [BW-1:0]    burst_inc;
    logic             load;
    logic             rd_pend, wr_pend;
    logic             rd_grant, wr_grant;

    assign rd_pend   = !i_rd_empty;
    assign wr_pend   = !i_wr_empty;
    assign burst_inc = (burst_q == BW'(DRAIN_BURST)) ? burst_q : burst_q + BW'(1);

    always_comb begin
        rd_grant = 1'b0;
        wr_grant = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;
        burst_d  = burst_q;
        case (state_q)
            READ_PRIO: begin
                if (load) begin
                    if (starve_q == SW'(STARVE_LIMIT) && wr_pend) begin
                        wr_grant = 1'b1;
                        starve_d = '0;
                    end else if (rd_pend) begin
                        rd_grant = 1'b1;
                        if (!wr_pend) begin
                            starve_d = '0;
                        end else if (starve_q != SW'(STARVE_LIMIT)) begin
                            starve_d = starve_q + SW'(1);
                        end
                    end else if (wr_pend) begin
                        wr_grant = 1'b1;
                        starve_d = '0;
                    end
                end
                // A read granted this cycle still issues; the drain starts next cycle.
                if (i_wr_full) begin
                    state_d = WRITE_DRAIN;
                    burst_d = '0;
                end
            end
            WRITE_DRAIN: begin
                if (load && wr_pend) begin
                    wr_grant = 1'b1;
                    burst_d  = burst_inc;
                end
                if (!wr_pend || (wr_grant && burst_inc == BW'(DRAIN_BURST))) begin
                    state_d  = READ_PRIO;
                    starve_d = '0;
                end
            end
            default: begin
                state_d = READ_PRIO;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= READ_PRIO;
            starve_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
        end
    end

    assign o_rd_pop       = rd_grant && i_rst_n;
    assign o_wr_pop       = wr_grant && i_rst_n;
    assign o_drain_active = (state_q == WRITE_DRAIN);

    cmd_issue_slot u_slot (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_push          (o_rd_pop || o_wr_pop),
        .i_push_cmd      (o_wr_pop ? i_wr_cmd : i_rd_cmd),
        .i_push_is_write (o_wr_pop),
        .i_ready         (i_cmd_ready),
        .o_load          (load),
        .o_valid         (o_cmd_valid),
        .o_cmd           (o_cmd),
        .o_is_write      (o_cmd_is_write)
    );

endmodule

// File: tb/tb_rw_request_scheduler.sv
// Bench: FIFO queues feed the scheduler; a queue-level reference model predicts pops and the slot every cycle.
module tb_rw_request_scheduler;
    import rw_request_scheduler_pkg::*;

    localparam int SL    = 8;
    localparam int DB    = 4;
    localparam int DEPTH = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    frontend_command_t i_rd_cmd = '0;
    logic              i_rd_empty = 1'b1;
    logic              o_rd_pop;
    frontend_command_t i_wr_cmd = '0;
    logic              i_wr_empty = 1'b1;
    logic              i_wr_full = 1'b0;
    logic              o_wr_pop;
    logic              o_cmd_valid;
    frontend_command_t o_cmd;
    logic              o_cmd_is_write;
    logic              i_cmd_ready = 1'b0;
    logic              o_drain_active;

    rw_request_scheduler #(.STARVE_LIMIT(SL), .DRAIN_BURST(DB)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rd_cmd       (i_rd_cmd),
        .i_rd_empty     (i_rd_empty),
        .o_rd_pop       (o_rd_pop),
        .i_wr_cmd       (i_wr_cmd),
        .i_wr_empty     (i_wr_empty),
        .i_wr_full      (i_wr_full),
        .o_wr_pop       (o_wr_pop),
        .o_cmd_valid    (o_cmd_valid),
        .o_cmd          (o_cmd),
        .o_cmd_is_write (o_cmd_is_write),
        .i_cmd_ready    (i_cmd_ready),
        .o_drain_active (o_drain_active)
    );

    always #5 i_clk = ~i_clk;

    frontend_command_t rd_q[$];
    frontend_command_t wr_q[$];
    bit                iss_w[$];
    int                errors = 0;
    int                checks = 0;
    int                tag_ctr = 0;

    // Reference model state
    bit                m_valid = 0;
    frontend_command_t m_cmd = '0;
    bit                m_isw = 0;
    bit                m_drain = 0;
    int                m_reads_ahead = 0;
    int                m_burst = 0;

    int                s_pops = 0;
    int                s_drain_cycles = 0;
    bit                s_rd_pop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_rd(input int n);
        frontend_command_t c;
        for (int i = 0; i < n; i++) begin
            if (rd_q.size() < DEPTH) begin
                c.addr = 24'($urandom);
                c.tag  = 8'(tag_ctr);
                tag_ctr++;
                rd_q.push_back(c);
            end
        end
    endtask

    task automatic push_wr(input int n);
        frontend_command_t c;
        for (int i = 0; i < n; i++) begin
            if (wr_q.size() < DEPTH) begin
                c.addr = 24'($urandom);
                c.tag  = 8'(tag_ctr);
                tag_ctr++;
                wr_q.push_back(c);
            end
        end
    endtask

    task automatic do_cycle(input bit rstn, input bit rdy, input bit ffull);
        bit load, rd_av, wr_av, pr, pw, full;
        i_rst_n     = rstn;
        i_cmd_ready = rdy;
        rd_av       = rd_q.size() != 0;
        wr_av       = wr_q.size() != 0;
        full        = (wr_q.size() >= DEPTH) || ffull;
        i_rd_empty  = !rd_av;
        i_rd_cmd    = rd_av ? rd_q[0] : '0;
        i_wr_empty  = !wr_av;
        i_wr_cmd    = wr_av ? wr_q[0] : '0;
        i_wr_full   = full;
        #1;
        pr   = 0;
        pw   = 0;
        load = !m_valid || rdy;
        if (rstn && load) begin
            if (m_drain)                           pw = wr_av;
            else if (m_reads_ahead >= SL && wr_av) pw = 1;
            else if (rd_av)                        pr = 1;
            else if (wr_av)                        pw = 1;
        end
        chk("rd_pop", o_rd_pop, pr);
        chk("wr_pop", o_wr_pop, pw);
        chk("cmd_valid", o_cmd_valid, m_valid);
        chk("drain_active", o_drain_active, m_drain);
        if (m_valid) begin
            chk("cmd", o_cmd, m_cmd);
            chk("cmd_is_write", o_cmd_is_write, m_isw);
        end
        s_pops   += int'(o_rd_pop) + int'(o_wr_pop);
        s_rd_pop  = o_rd_pop;
        if (o_drain_active) s_drain_cycles++;
        @(posedge i_clk);
        if (!rstn) begin
            m_valid = 0; m_cmd = '0; m_isw = 0;
            m_drain = 0; m_reads_ahead = 0; m_burst = 0;
        end else begin
            if (m_valid && rdy) iss_w.push_back(m_isw);
            if (!m_drain) begin
                if (pw)      m_reads_ahead = 0;
                else if (pr) m_reads_ahead = wr_av ? ((m_reads_ahead + 1 > SL) ? SL : m_reads_ahead + 1) : 0;
                if (full) begin m_drain = 1; m_burst = 0; end
            end else begin
                if (pw) m_burst++;
                if (!wr_av || m_burst == DB) begin m_drain = 0; m_reads_ahead = 0; end
            end
            if (load) begin
                m_valid = pr || pw;
                if (pr) begin m_cmd = rd_q.pop_front(); m_isw = 0; end
                else if (pw) begin m_cmd = wr_q.pop_front(); m_isw = 1; end
            end
        end
        @(negedge i_clk);
    endtask

    task automatic clean_reset();
        rd_q.delete();
        wr_q.delete();
        do_cycle(0, 1, 0);
        iss_w.delete();
        s_pops = 0;
        s_drain_cycles = 0;
    endtask

    initial begin
        bit exp_order[11];
        // Registers are unknown before the first reset edge; do not compare yet.
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);

        // Reset with both FIFOs non-empty and ready high.
        push_rd(3); push_wr(3);
        s_pops = 0;
        do_cycle(0, 1, 0);
        do_cycle(0, 1, 0);
        chk("rst_pops", s_pops, 0);
        chk("rst_valid", o_cmd_valid, 0);
        chk("rst_cmd", o_cmd, 0);
        do_cycle(1, 1, 0);
        chk("rst_first_pop", s_rd_pop, 1);
        for (int i = 0; i < 10; i++) do_cycle(1, 1, 0);

        // Read priority with starvation guard.
        clean_reset();
        push_rd(10); push_wr(1);
        for (int i = 0; i < 14; i++) do_cycle(1, 1, 0);
        exp_order = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        chk("prio_count", iss_w.size(), 11);
        for (int i = 0; i < 11; i++)
            if (i < iss_w.size()) chk("prio_order", iss_w[i], exp_order[i]);

        // Backpressure: 5 stalled cycles, then gap-free issue.
        clean_reset();
        push_rd(8);
        do_cycle(1, 1, 0);
        do_cycle(1, 1, 0);
        s_pops = 0;
        for (int i = 0; i < 5; i++) do_cycle(1, 0, 0);
        chk("stall_pops", s_pops, 0);
        for (int i = 0; i < 6; i++) do_cycle(1, 1, 0);
        chk("bp_issued", iss_w.size(), 7);

        // Drain on full write FIFO.
        clean_reset();
        push_rd(4); push_wr(DEPTH);
        for (int i = 0; i < 30; i++) do_cycle(1, 1, 0);
        chk("drain_cycles", s_drain_cycles, 4);
        exp_order = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 6; i++)
            if (i < iss_w.size()) chk("drain_order", iss_w[i], exp_order[i]);

        // Drain exit on empty.
        clean_reset();
        push_wr(2);
        do_cycle(1, 1, 1);
        for (int i = 0; i < 5; i++) do_cycle(1, 1, 0);
        chk("empty_exit_issued", iss_w.size(), 2);
        chk("empty_exit_drain_cycles", s_drain_cycles, 2);
        chk("empty_exit_state", o_drain_active, 0);

        // Reset while a command is stalled in the slot.
        clean_reset();
        push_rd(1); push_wr(1);
        do_cycle(1, 0, 0);
        do_cycle(1, 0, 0);
        do_cycle(0, 0, 0);
        chk("midrst_valid", o_cmd_valid, 0);
        for (int i = 0; i < 4; i++) do_cycle(1, 1, 0);
        chk("midrst_issued", iss_w.size(), 1);
        if (iss_w.size() > 0) chk("midrst_kind", iss_w[0], 1);

        // Randomized traffic with backpressure, full pulses and rare resets.
        clean_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 35) push_rd(1);
            if ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 60)) push_wr(1);
            do_cycle($urandom_range(0, 599) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 79) == 0);
        end
        for (int i = 0; i < 60; i++) do_cycle(1, 1, 0);
        chk("final_rd_empty", rd_q.size(), 0);
        chk("final_wr_empty", wr_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
